// File: rtl/fpu_types.sv
// Shared types for the FPU writeback path: the queued result entry and flag width.
// Widths default to the build-wide register/data/commit-id macros when those are not predefined.
`ifndef FREG_DATA_WIDTH
`define FREG_DATA_WIDTH 32
`endif
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 5
`endif
`ifndef COMMIT_ID_WIDTH
`define COMMIT_ID_WIDTH 4
`endif

package fpu_types;

  localparam int FFLAGS_W = 5;
  localparam int DATA_W   = `FREG_DATA_WIDTH;
  localparam int ADDR_W   = `REG_ADDR_WIDTH;
  localparam int CID_W    = `COMMIT_ID_WIDTH;

  typedef struct packed {
    logic [ADDR_W-1:0]   waddr;
    logic [DATA_W-1:0]   wdata;
    logic [CID_W-1:0]    commit_id;
    logic                fcsr_we;
    logic [FFLAGS_W-1:0] fflags;
  } fpu_wb_entry_t;

endpackage

// File: rtl/fpu_wb_fifo.sv
// Generic DEPTH-entry register FIFO; the head entry is read straight from storage,
// so a push becomes visible one cycle later and there is no bypass path.
module fpu_wb_fifo
  import fpu_types::*;
#(
  parameter int  DEPTH   = 2,
  parameter type entry_t = fpu_wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push,
  input  logic   pop,
  input  entry_t wdata,
  output entry_t rdata,
  output logic   full,
  output logic   empty
);

  localparam int PW = $clog2(DEPTH);

  entry_t        mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: storage is reset because the head entry drives the outputs directly and must read as zero.
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_wb_queue.sv
// FPU writeback queue: in-order result buffer, sticky architectural fflags, and the
// pending indication that lets CSR reads of fflags stall until queued flags retire.
module fpu_wb_queue
  import fpu_types::*;
#(
  parameter int DEPTH = 2,
  parameter int DW    = DATA_W,
  parameter int AW    = ADDR_W,
  parameter int CW    = CID_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                fpu_reg_we_i,
  input  logic [AW-1:0]       fpu_reg_waddr_i,
  input  logic [DW-1:0]       fpu_reg_wdata_i,
  input  logic [CW-1:0]       fpu_commit_id_i,
  input  logic                fpu_fcsr_we_i,
  input  logic [FFLAGS_W-1:0] fpu_fflags_i,
  input  logic                fpu_fflags_pending_i,
  output logic                fpu_wb_ready_o,
  output logic                wb_valid_o,
  input  logic                wb_ready_i,
  output logic [AW-1:0]       wb_waddr_o,
  output logic [DW-1:0]       wb_wdata_o,
  output logic [CW-1:0]       wb_commit_id_o,
  input  logic                csr_fflags_we_i,
  input  logic [FFLAGS_W-1:0] csr_fflags_i,
  output logic [FFLAGS_W-1:0] fflags_o,
  output logic                fflags_pending_o
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fpu_wb_entry_t       in_entry;
  fpu_wb_entry_t       head;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [CNT_W-1:0]    flag_cnt;
  logic [CNT_W-1:0]    flag_cnt_nxt;
  logic [FFLAGS_W-1:0] fflags_nxt;

  assign in_entry = '{waddr:     fpu_reg_waddr_i,
                      wdata:     fpu_reg_wdata_i,
                      commit_id: fpu_commit_id_i,
                      fcsr_we:   fpu_fcsr_we_i,
                      fflags:    fpu_fflags_i};

  // Ready is derived from occupancy only, so a full queue refuses a push even while it pops.
  assign fpu_wb_ready_o = ~fifo_full;
  assign wb_valid_o     = ~fifo_empty;
  assign push           = fpu_reg_we_i & fpu_wb_ready_o;
  assign pop            = wb_valid_o & wb_ready_i;

  fpu_wb_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fpu_wb_entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (in_entry),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign wb_waddr_o     = head.waddr;
  assign wb_wdata_o     = head.wdata;
  assign wb_commit_id_o = head.commit_id;

  // Counting flagged entries avoids scanning the storage for the pending indication.
  always_comb begin
    flag_cnt_nxt = flag_cnt;
    if (push && fpu_fcsr_we_i) flag_cnt_nxt = flag_cnt_nxt + CNT_W'(1);
    if (pop && head.fcsr_we)   flag_cnt_nxt = flag_cnt_nxt - CNT_W'(1);
  end

  // Retiring flags are ORed on top of a coincident CSR write, so no exception is lost.
  always_comb begin
    fflags_nxt = csr_fflags_we_i ? csr_fflags_i : fflags_o;
    if (pop && head.fcsr_we) fflags_nxt = fflags_nxt | head.fflags;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_cnt <= '0;
      fflags_o <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      flag_cnt <= flag_cnt_nxt;
      fflags_o <= fflags_nxt;
    end
  end

  assign fflags_pending_o = fpu_fflags_pending_i | (flag_cnt != '0);

endmodule
